// File: rtl/alu_seq_handshake.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_handshake
// Purpose  : ALU with registered outputs and valid/ready handshakes on the
//            input and output sides. Single-cycle logic, arithmetic, shift
//            and compare ops. MUL is an iterative shift-add unit that retires
//            MUL_STEP multiplier bits per cycle.
// Ports    : clk        rising-edge clock
//            rst_n      synchronous active-low reset
//            in_valid   operands/op valid       in_ready   op can be accepted
//            a, b       WIDTH-bit operands      alu_op     4-bit op code
//            out_valid  result/flags valid      out_ready  consumer takes result
//            result     registered result       zero       result == 0
//            bge        result MSB clear        illegal    undefined op code
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_handshake #(
    parameter int WIDTH    = 64,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             bge,
    output logic             illegal
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int NSTEP = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(NSTEP + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MUL_RUN = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, bge_q, illegal_q;
    logic [WIDTH-1:0] mul_a_q, mul_b_q, acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic             load;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] load_val;
    logic             load_illegal;

    assign accept   = in_valid & in_ready;
    assign is_mul   = (alu_op == OP_MUL);
    assign mul_last = (state_q == ST_MUL_RUN) && (cnt_q == CNT_LAST);
    assign shamt    = b[SHW-1:0];

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (alu_op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: alu_res = a + b;
            OP_SUB: alu_res = a - b;
            OP_NOR: alu_res = ~(a | b);
            OP_SLL: alu_res = a << shamt;
            OP_SRL: alu_res = a >> shamt;
            OP_SRA: alu_res = $signed(a) >>> shamt;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL: alu_res = '0;   // handled by the iterative unit
            default: alu_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add step: sum of (a << j) for each set bit j of the low
    // MUL_STEP multiplier bits.
    // ------------------------------------------------------------------
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mul_b_q[j]) begin
                partial = partial + (mul_a_q << j);
            end
        end
    end

    assign acc_sum = acc_q + partial;

    // The result register is loaded either by an accepted single-cycle op
    // or by the final multiplier step; accept cannot occur in MUL_RUN.
    assign load         = (accept & ~is_mul) | mul_last;
    assign load_val     = (state_q == ST_MUL_RUN) ? acc_sum : alu_res;
    assign load_illegal = (state_q == ST_MUL_RUN) ? 1'b0 : alu_illegal;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = is_mul ? ST_MUL_RUN : ST_DONE;
                end
            end
            ST_MUL_RUN: begin
                if (mul_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = is_mul ? ST_MUL_RUN : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. In DONE, a new op can only enter as the held result
    // leaves, so in_ready follows out_ready combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            bge_q     <= 1'b1;
            illegal_q <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (load) begin
                result_q  <= load_val;
                zero_q    <= (load_val == '0);
                bge_q     <= ~load_val[WIDTH-1];
                illegal_q <= load_illegal;
            end
            if (accept && is_mul) begin
                mul_a_q <= a;
                mul_b_q <= b;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (state_q == ST_MUL_RUN) begin
                acc_q   <= acc_sum;
                mul_a_q <= mul_a_q << MUL_STEP;
                mul_b_q <= mul_b_q >> MUL_STEP;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign bge     = bge_q;
    assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_handshake.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_handshake
// Purpose  : Self-checking bench for alu_seq_handshake (WIDTH=64) with
//            MUL_STEP=1 and a second MUL_STEP=4 instance; directed and
//            random ops compared against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_handshake;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] a, b, result;
    logic [3:0]  alu_op;
    logic        zero, bge, illegal;

    logic        d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
    logic [63:0] d4_a, d4_b, d4_result;
    logic [3:0]  d4_alu_op;
    logic        d4_zero, d4_bge, d4_illegal;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] last_res;

    always #5 clk = ~clk;

    alu_seq_handshake #(.WIDTH(64), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .bge(bge), .illegal(illegal)
    );

    alu_seq_handshake #(.WIDTH(64), .MUL_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .alu_op(d4_alu_op),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready),
        .result(d4_result), .zero(d4_zero), .bge(d4_bge), .illegal(d4_illegal)
    );

    // Reference model: {illegal, result} straight from the op definitions.
    function automatic logic [64:0] model(input logic [3:0] op,
                                          input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        int          sh;
        sh = int'(y % 64);
        r  = '0;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b1100: r = ~(x | y);
            4'b0011: r = x << sh;
            4'b0100: r = x >> sh;
            4'b0101: r = $signed(x) >>> sh;
            4'b0111: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'b1000: r = x * y;
            default: return {1'b1, 64'd0};
        endcase
        return {1'b0, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready high, wait for its result, check it.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [63:0] x, input logic [63:0] y);
        logic [64:0] m;
        int          cyc;
        int          lowrdy;
        m = model(op, x, y);
        alu_op = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; alu_op = 4'($urandom);
        cyc = 1; lowrdy = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (in_ready === 1'b0) lowrdy++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), (op == 4'b1000) ? 64'd65 : 64'd1);
        if (op == 4'b1000) check({tag, " busy cycles"}, 64'(lowrdy), 64'd64);
        check({tag, " result"},  result, m[63:0]);
        check({tag, " zero"},    64'(zero), (m[63:0] == 64'd0) ? 64'd1 : 64'd0);
        check({tag, " bge"},     64'(bge), m[63] ? 64'd0 : 64'd1);
        check({tag, " illegal"}, 64'(illegal), 64'(m[64]));
        last_res = result;
    endtask

    initial begin
        logic [64:0] m;
        logic [63:0] xs, ys, held;
        int          cyc, lowrdy, seen;
        logic [3:0]  op;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alu_op = '0;
        d4_in_valid = 1'b0; d4_out_ready = 1'b1; d4_a = '0; d4_b = '0; d4_alu_op = '0;
        repeat (3) @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready",  64'(in_ready),  64'd1);
        check("rst result",    result,         64'd0);
        check("rst zero",      64'(zero),      64'd1);
        check("rst bge",       64'(bge),       64'd1);
        check("rst illegal",   64'(illegal),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_op("add 5+3", 4'b0010, 64'd5, 64'd3);
        check("add 5+3 const", last_res, 64'd8);
        run_op("sub 3-5", 4'b0110, 64'd3, 64'd5);
        check("sub 3-5 const", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("sub 7-7", 4'b0110, 64'd7, 64'd7);
        run_op("mul step1", 4'b1000, 64'h1_0000_0001, 64'd3);
        check("mul step1 const", last_res, 64'h3_0000_0003);
        run_op("sra 67", 4'b0101, 64'h8000_0000_0000_0000, 64'd67);
        check("sra 67 const", last_res, 64'hF000_0000_0000_0000);
        run_op("slt -1<1", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("slt const", last_res, 64'd1);
        run_op("illegal 1111", 4'b1111, 64'd9, 64'd4);
        run_op("sll 63", 4'b0011, 64'd1, 64'd63);
        run_op("nor 0", 4'b1100, 64'd0, 64'd0);

        // Drain to IDLE, then hold the output with out_ready low
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        xs = {$urandom, $urandom}; ys = {$urandom, $urandom};
        m = model(4'b0010, xs, ys);
        alu_op = 4'b0010; a = xs; b = ys; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold out_valid", 64'(out_valid), 64'd1);
            check("hold in_ready",  64'(in_ready),  64'd0);
            check("hold result",    result,         m[63:0]);
            check("hold zero",      64'(zero),      (m[63:0] == 64'd0) ? 64'd1 : 64'd0);
            @(negedge clk);
        end

        // Back-to-back AND stream
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xs = {$urandom, $urandom}; ys = {$urandom, $urandom};
            alu_op = 4'b0000; a = xs; b = ys; in_valid = 1'b1;
            @(negedge clk);
            check("stream out_valid", 64'(out_valid), 64'd1);
            check("stream result",    result,         xs & ys);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream end idle", 64'(out_valid), 64'd0);

        // Reset during MUL_RUN aborts the op
        xs = {$urandom, $urandom}; ys = {$urandom, $urandom};
        alu_op = 4'b1000; a = xs; b = ys; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mulrun busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort in_ready",  64'(in_ready),  64'd1);
        check("abort result",    result,         64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("abort no output", 64'(seen), 64'd0);

        // Random ops against the model
        for (int i = 0; i < 30; i++) begin
            op = (i % 6 == 5) ? 4'b1000 : 4'($urandom_range(0, 15));
            xs = {$urandom, $urandom};
            ys = (i % 2 == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
            run_op("random", op, xs, ys);
        end

        // MUL_STEP=4 instance
        d4_alu_op = 4'b1000; d4_a = 64'h1_0000_0001; d4_b = 64'd3; d4_in_valid = 1'b1;
        check("m4 in_ready", 64'(d4_in_ready), 64'd1);
        @(negedge clk);
        d4_in_valid = 1'b0;
        cyc = 1; lowrdy = 0;
        while (d4_out_valid !== 1'b1 && cyc < 200) begin
            if (d4_in_ready === 1'b0) lowrdy++;
            @(negedge clk);
            cyc++;
        end
        check("m4 latency", 64'(cyc),    64'd17);
        check("m4 busy",    64'(lowrdy), 64'd16);
        check("m4 result",  d4_result,   64'h3_0000_0003);
        held = d4_result;
        check("m4 illegal", 64'(d4_illegal), 64'd0);
        xs = {$urandom, $urandom}; ys = {$urandom, $urandom};
        @(negedge clk);
        d4_alu_op = 4'b1000; d4_a = xs; d4_b = ys; d4_in_valid = 1'b1;
        @(negedge clk);
        d4_in_valid = 1'b0;
        cyc = 1;
        while (d4_out_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        m = model(4'b1000, xs, ys);
        check("m4 rand result", d4_result, m[63:0]);
        check("m4 rand latency", 64'(cyc), 64'd17);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
